// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - two-requester arbiter sharing one combinational 8x8 multiplier
// One operation in flight; round-robin priority flips to the other requester after each response.
module mul_arbiter #(
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_y,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_y,
    input  logic        rsp1_ready,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_y,
    output logic        busy,
    output logic [15:0] done_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        r_owner;
    logic [3:0]  r_cnt;
    logic [7:0]  r_op_a;
    logic [7:0]  r_op_b;
    logic [15:0] r_result;
    logic [15:0] r_done_cnt;

    logic w_idle;
    logic w_resp;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_rsp_hs;

    // Sole valid requester wins; on contention the priority pointer decides.
    assign w_grant0   = req0_valid & (~req1_valid | ~r_prio);
    assign w_grant1   = req1_valid & (~req0_valid | r_prio);
    assign w_idle     = (r_state == S_IDLE);
    assign w_resp     = (r_state == S_RESP);
    assign req0_ready = w_idle & ~rst & w_grant0;
    assign req1_ready = w_idle & ~rst & w_grant1;
    assign w_accept   = req0_ready | req1_ready;
    assign w_rsp_hs   = w_resp & (r_owner ? rsp1_ready : rsp0_ready);

    assign rsp0_valid = w_resp & ~r_owner;
    assign rsp1_valid = w_resp & r_owner;
    assign rsp0_y     = rsp0_valid ? r_result : 16'h0000;
    assign rsp1_y     = rsp1_valid ? r_result : 16'h0000;
    assign mul_a      = r_op_a;
    assign mul_b      = r_op_b;
    assign busy       = ~w_idle;
    assign done_cnt   = r_done_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio     <= 1'b0;
            r_owner    <= 1'b0;
            r_cnt      <= 4'd0;
            r_op_a     <= 8'd0;
            r_op_b     <= 8'd0;
            r_result   <= 16'd0;
            r_done_cnt <= 16'd0;
        end else begin
            if (w_accept) begin
                r_op_a  <= req1_ready ? req1_a : req0_a;
                r_op_b  <= req1_ready ? req1_b : req0_b;
                r_owner <= req1_ready;
                r_cnt   <= CNT_LOAD;
            end
            // The multiplier has settled once the countdown reaches zero.
            if (r_state == S_WAIT) begin
                if (r_cnt == 4'd0) begin
                    r_result <= mul_y;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
            if (w_rsp_hs) begin
                r_prio     <= ~r_owner;
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end
endmodule
